// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundle of the branch/jump resolution inputs and the fetch-side
//             outputs exchanged between the PC sequencer and its pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);
  // Requests arriving from fetch and execute
  logic             if_ready;
  logic             stall;
  logic             br_valid;
  logic             br_taken;
  logic [31:0]      br_pc;
  logic [31:0]      immediate;
  logic             jmp_valid;
  logic [25:0]      jmp_target;

  // Fetch request and redirect status produced by the sequencer
  logic [31:0]      pc;
  logic             pc_valid;
  logic             flush;
  logic [CNT_W-1:0] redirect_cnt;

  // Sequencer side
  modport master (
    input  if_ready, stall, br_valid, br_taken, br_pc, immediate,
           jmp_valid, jmp_target,
    output pc, pc_valid, flush, redirect_cnt
  );

  // Pipeline side
  modport slave (
    output if_ready, stall, br_valid, br_taken, br_pc, immediate,
           jmp_valid, jmp_target,
    input  pc, pc_valid, flush, redirect_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch PC generator. Advances the PC sequentially, redirects on
//             taken branches and jumps (jump has priority), inserts a single
//             flush bubble per redirect and counts redirects (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pc_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_target;
  logic [31:0]      w_jmp_target;
  logic [31:0]      w_target;
  logic             w_redirect;
  logic [CNT_W-1:0] w_cnt_next;

  // Redirect target selection; the jump wins over a simultaneous taken branch
  always_comb begin
    w_pc_plus4   = bus.br_pc + 32'd4;
    // Word offset scaled to bytes; the top two offset bits shift out.
    w_br_target  = (w_pc_plus4 + (bus.immediate << 2)) & 32'hFFFF_FFFC;
    w_jmp_target = {w_pc_plus4[31:28], bus.jmp_target, 2'b00};
    w_redirect   = bus.jmp_valid | (bus.br_valid & bus.br_taken);
    w_target     = bus.jmp_valid ? w_jmp_target : w_br_target;
    w_cnt_next   = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state logic: INIT waits one cycle, RUN advances or redirects,
  // BUBBLE holds for one cycle per redirect
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (w_redirect) begin
          pc_d    = w_target;
          state_d = S_BUBBLE;
          flush_d = 1'b1;
          cnt_d   = w_cnt_next;
        end else if (bus.if_ready && !bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_BUBBLE: begin
        if (w_redirect) begin
          pc_d    = w_target;
          flush_d = 1'b1;
          cnt_d   = w_cnt_next;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State registers with synchronous reset overriding every request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs; the fetch request is valid only while running
  always_comb begin
    bus.pc           = pc_q;
    bus.pc_valid     = (state_q == S_RUN);
    bus.flush        = flush_q;
    bus.redirect_cnt = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer: directed scenarios with
//             literal expectations, then randomized traffic compared each
//             cycle against a behavioural model (16-bit and 2-bit counters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_ready = 1'b0, stall = 1'b0;
  logic        br_valid = 1'b0, br_taken = 1'b0, jmp_valid = 1'b0;
  logic [31:0] br_pc = '0, immediate = '0;
  logic [25:0] jmp_target = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(16)) bus16 ();
  pc_sequencer_if #(.CNT_W(2))  bus2  ();

  // Same stimulus on both instances
  assign bus16.if_ready = if_ready;   assign bus2.if_ready = if_ready;
  assign bus16.stall = stall;         assign bus2.stall = stall;
  assign bus16.br_valid = br_valid;   assign bus2.br_valid = br_valid;
  assign bus16.br_taken = br_taken;   assign bus2.br_taken = br_taken;
  assign bus16.br_pc = br_pc;         assign bus2.br_pc = br_pc;
  assign bus16.immediate = immediate; assign bus2.immediate = immediate;
  assign bus16.jmp_valid = jmp_valid; assign bus2.jmp_valid = jmp_valid;
  assign bus16.jmp_target = jmp_target; assign bus2.jmp_target = jmp_target;

  pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = '0;
  bit          m_valid = 0, m_flush = 0, m_started = 0, m_known = 0;
  int unsigned m_redirects = 0;

  always @(posedge clk) begin
    logic        redir;
    logic [31:0] tgt;
    redir = jmp_valid || (br_valid && br_taken);
    if (jmp_valid)
      tgt = ((br_pc + 32'd4) & 32'hF000_0000) | (32'(jmp_target) * 32'd4);
    else
      tgt = (br_pc + 32'd4 + immediate * 32'd4) & ~32'd3;
    if (reset) begin
      m_known = 1; m_pc = RESET_PC; m_valid = 0; m_flush = 0;
      m_started = 0; m_redirects = 0;
    end else if (m_known) begin
      if (!m_started) begin
        m_started = 1; m_valid = 1; m_flush = 0;
      end else if (redir) begin
        m_pc = tgt; m_valid = 0; m_flush = 1; m_redirects++;
      end else if (m_valid) begin
        if (if_ready && !stall) m_pc = m_pc + 32'd4;
        m_flush = 0;
      end else begin
        m_valid = 1; m_flush = 0;
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc16",    bus16.pc,                  m_pc);
      chk("valid16", 32'(bus16.pc_valid),       32'(m_valid));
      chk("flush16", 32'(bus16.flush),          32'(m_flush));
      chk("cnt16",   32'(bus16.redirect_cnt),   (m_redirects > 65535) ? 32'd65535 : m_redirects);
      chk("pc2",     bus2.pc,                   m_pc);
      chk("flush2",  32'(bus2.flush),           32'(m_flush));
      chk("cnt2",    32'(bus2.redirect_cnt),    (m_redirects > 3) ? 32'd3 : m_redirects);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_ready = 1'b1; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_pc = '0; immediate = '0; jmp_valid = 1'b0; jmp_target = '0;
  endtask

  task automatic branch(input logic [31:0] bpc, input logic [31:0] imm, input logic taken);
    br_valid = 1'b1; br_taken = taken; br_pc = bpc; immediate = imm;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_pc", bus16.pc, 32'h0);
    chk("rst_valid", 32'(bus16.pc_valid), 32'd0);
    chk("rst_flush", 32'(bus16.flush), 32'd0);
    chk("rst_cnt", 32'(bus16.redirect_cnt), 32'd0);

    // Reset release and sequential fetch
    reset = 1'b0;
    cyc(); chk("seq0_valid", 32'(bus16.pc_valid), 32'd1); chk("seq0", bus16.pc, 32'h0);
    cyc(); chk("seq1", bus16.pc, 32'h4);
    cyc(); chk("seq2", bus16.pc, 32'h8);

    // Backward branch of -1 word
    branch(32'h100, 32'hFFFF_FFFF, 1'b1);
    cyc(); idle();
    chk("br1_flush", 32'(bus16.flush), 32'd1);
    chk("br1_bubble", 32'(bus16.pc_valid), 32'd0);
    cyc();
    chk("br1_flush_end", 32'(bus16.flush), 32'd0);
    chk("br1_pc", bus16.pc, 32'h100);
    chk("br1_valid", 32'(bus16.pc_valid), 32'd1);
    chk("br1_cnt", 32'(bus16.redirect_cnt), 32'd1);

    // Large offset with upper offset bits discarded, then not-taken
    branch(32'h100, 32'hABCD_F123, 1'b1);
    cyc(); idle(); cyc();
    chk("br2_pc", bus16.pc, 32'hAF37_C590);
    branch(32'h100, 32'hABCD_F123, 1'b0);
    cyc(); idle();
    chk("nt_pc", bus16.pc, 32'hAF37_C594);
    chk("nt_flush", 32'(bus16.flush), 32'd0);

    // Jump beats simultaneous taken branch
    branch(32'h0040_0010, 32'd5, 1'b1);
    jmp_valid = 1'b1; jmp_target = 26'h000_0040;
    cyc(); idle();
    chk("jmp_flush", 32'(bus16.flush), 32'd1);
    cyc();
    chk("jmp_pc", bus16.pc, 32'h100);
    chk("jmp_one_flush", 32'(bus16.flush), 32'd0);
    chk("jmp_cnt", 32'(bus16.redirect_cnt), 32'd3);

    // Stall freezes the PC but not a redirect
    stall = 1'b1;
    cyc(); cyc();
    chk("stall_pc", bus16.pc, 32'h100);
    branch(32'h200, 32'd4, 1'b1);
    cyc(); idle(); stall = 1'b1;
    chk("stall_br_flush", 32'(bus16.flush), 32'd1);
    cyc();
    chk("stall_br_pc", bus16.pc, 32'h214);
    chk("stall_br_valid", 32'(bus16.pc_valid), 32'd1);
    cyc();
    chk("stall_hold", bus16.pc, 32'h214);
    stall = 1'b0;

    // PC wrap
    branch(32'hFFFF_FFF8, 32'd0, 1'b1);
    cyc(); idle(); cyc();
    chk("wrap_pre", bus16.pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_post", bus16.pc, 32'h0);

    // Reset during bubble, then a jump in INIT is ignored
    branch(32'h40, 32'd0, 1'b1);
    cyc();
    chk("rb_flush_pre", 32'(bus16.flush), 32'd1);
    reset = 1'b1; jmp_valid = 1'b1; jmp_target = 26'h3;
    cyc();
    chk("rb_flush", 32'(bus16.flush), 32'd0);
    chk("rb_pc", bus16.pc, RESET_PC);
    chk("rb_cnt", 32'(bus16.redirect_cnt), 32'd0);
    reset = 1'b0; idle(); jmp_valid = 1'b1; jmp_target = 26'h3;
    cyc(); idle();
    chk("init_ign_pc", bus16.pc, RESET_PC);
    chk("init_ign_valid", 32'(bus16.pc_valid), 32'd1);
    chk("init_ign_flush", 32'(bus16.flush), 32'd0);

    // Counter saturation in the 2-bit instance
    jmp_valid = 1'b1; jmp_target = 26'h10;
    repeat (5) cyc();
    idle(); cyc();
    chk("sat_cnt16", 32'(bus16.redirect_cnt), 32'd5);
    chk("sat_cnt2", 32'(bus2.redirect_cnt), 32'd3);
    chk("sat_pc", bus16.pc, 32'h40);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      if_ready   = 1'($urandom_range(0, 3) != 0);
      stall      = 1'($urandom_range(0, 3) == 0);
      br_valid   = 1'($urandom_range(0, 3) == 0);
      br_taken   = 1'($urandom_range(0, 1));
      br_pc      = $urandom();
      immediate  = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(8'($urandom())));
      jmp_valid  = 1'($urandom_range(0, 9) == 0);
      jmp_target = 26'($urandom());
      cyc();
    end
    reset = 1'b0; idle();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded by reset.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the redirect counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 if_ready  input  1  SHALL indicate that the fetch stage accepts the current pc this cycle.
REQ-006 stall  input  1  SHALL request that the sequential PC advance be frozen.
REQ-007 br_valid  input  1  SHALL mark a resolved conditional branch.
REQ-008 br_taken  input  1  SHALL be the branch outcome, qualified by br_valid.
REQ-009 br_pc  input  32  SHALL be the address of the branch instruction.
REQ-010 immediate  input  32  SHALL be the sign-extended branch offset, in words.
REQ-011 jmp_valid  input  1  SHALL mark an unconditional jump.
REQ-012 jmp_target  input  26  SHALL be the jump instruction index field.
REQ-013 pc  output  32  SHALL be the current fetch address.
REQ-014 pc_valid  output  1  SHALL mark pc as a valid fetch request.
REQ-015 flush  output  1  SHALL be a one-cycle pulse that squashes younger in-flight instructions.
REQ-016 redirect_cnt  output  CNT_W  SHALL count taken redirects.

Function
REQ-017 Branch target SHALL be br_pc + 4 + {immediate[29:0], 2'b00}, computed modulo 2^32, with carry out discarded.
REQ-018 Jump target SHALL be {pc_plus4[31:28], jmp_target, 2'b00}, where pc_plus4 = br_pc + 4.
REQ-019 A redirect SHALL occur when jmp_valid=1, or when br_valid=1 and br_taken=1.
REQ-020 When jmp_valid and a taken branch arrive in the same cycle, the jump SHALL win.
REQ-021 br_valid=1 with br_taken=0 SHALL have no effect on the sequencer.
REQ-022 The FSM SHALL have three states: INIT, RUN and BUBBLE.
REQ-023 INIT SHALL move to RUN unconditionally after one cycle, with pc_valid=0 and pc held at RESET_PC.
REQ-024 In RUN with pc_valid=1:
  - redirect present: pc <= target, state <= BUBBLE;
  - else if_ready=1 and stall=0: pc <= pc + 4;
  - otherwise: pc holds.
REQ-025 A redirect SHALL override stall and SHALL not depend on if_ready.
REQ-026 On entry to BUBBLE, the flush register SHALL be set; flush SHALL therefore be 1 for exactly the one cycle spent in BUBBLE.
REQ-027 In BUBBLE, pc_valid SHALL be 0.
REQ-028 From BUBBLE the state SHALL return to RUN, unless a new redirect arrives, in which case pc <= the new target and the state stays in BUBBLE for one more cycle.
REQ-029 A redirect in INIT SHALL be ignored.
REQ-030 pc_valid SHALL be 1 in RUN and 0 in INIT and BUBBLE.
REQ-031 Redirect latency SHALL be: request in cycle N -> flush=1 in N+1 -> pc_valid=1 with pc=target in N+2.
REQ-032 redirect_cnt SHALL increment once per accepted redirect and SHALL saturate at all-ones.
REQ-033 pc + 4 SHALL wrap from 32'hFFFFFFFC to 32'h00000000.
REQ-034 pc[1:0] SHALL always be 2'b00; target bits [1:0] SHALL be forced to 0.

Reset
REQ-035 With reset=1 at a clock edge, the block SHALL set pc=RESET_PC, pc_valid=0, flush=0, redirect_cnt=0 and state=INIT, overriding all other inputs.
REQ-036 Reset asserted mid-operation, including during BUBBLE, SHALL abandon any pending redirect; no flush SHALL be produced after the reset edge.

Verification
REQ-037 Reset release, if_ready=1 for 3 cycles -> pc_valid rises one cycle after release; pc sequence 0x0, 0x4, 0x8.
REQ-038 br_pc=0x100, immediate=32'hFFFFFFFF, taken -> flush pulses in N+1; pc=0x100 with pc_valid=1 in N+2; redirect_cnt=1.
REQ-039 br_pc=0x100, immediate=32'hABCDF123, taken -> pc=32'hAF37C590; the same case with br_taken=0 -> pc continues +4.
REQ-040 br_pc=0x00400010, jmp_valid=1, jmp_target=26'h0000040, plus a simultaneous taken branch -> pc=0x00000100 (jump wins); exactly one flush.
REQ-041 stall=1 held with if_ready=1 -> pc frozen; a taken branch arriving during stall -> redirect still occurs with standard latency.
REQ-042 Wrap and saturation checks:
  - pc=0xFFFFFFFC advanced -> 0x00000000;
  - CNT_W=2 with 5 redirects -> redirect_cnt=3;
  - reset in BUBBLE -> flush=0 and pc=RESET_PC.
